// File: rtl/systolic_seq_ctrl.sv
// Sequencer for a DEPTH-stage systolic array: clears the array, streams len words
// in, flushes them through, and hands captured results out over a valid/ready port.
module systolic_seq_ctrl #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             arr_shift,
    output logic             arr_clr,
    output logic [WIDTH-1:0] arr_in,
    input  logic [WIDTH-1:0] arr_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy,
    output logic             done
);

    // Shift counter must hold len+DEPTH (up to 16+DEPTH) without wrapping.
    localparam int SCW = ($clog2(DEPTH + 17) > 5) ? $clog2(DEPTH + 17) : 5;
    localparam logic [SCW-1:0] DEPTH_C = SCW'(DEPTH);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] CLEAR  = 3'd1;
    localparam logic [2:0] FILL   = 3'd2;
    localparam logic [2:0] DRAIN  = 3'd3;
    localparam logic [2:0] FINISH = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [SCW-1:0]   sc_q, sc_d;
    logic [SCW-1:0]   len_q, len_d;
    logic             ov_q, ov_d;
    logic [WIDTH-1:0] od_q, od_d;

    logic slot_ok, room, capture;

    assign slot_ok = !ov_q || out_ready;
    // Until the pipe is primed nothing reaches the output, so shifting needs no free slot.
    assign room    = slot_ok || (sc_q < DEPTH_C);
    assign capture = arr_shift && (sc_q >= DEPTH_C);

    always_comb begin
        state_d   = state_q;
        sc_d      = sc_q;
        len_d     = len_q;
        in_ready  = 1'b0;
        arr_shift = 1'b0;
        arr_clr   = 1'b0;
        arr_in    = '0;
        done      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = CLEAR;
                    len_d   = (len == 4'd0) ? SCW'(16) : SCW'(len);
                    sc_d    = '0;
                end
            end
            CLEAR: begin
                arr_clr = 1'b1;
                state_d = FILL;
            end
            FILL: begin
                in_ready  = room;
                arr_shift = in_valid && room;
                if (arr_shift) begin
                    arr_in = in_data;
                    if (sc_q + SCW'(1) == len_q)
                        state_d = DRAIN;
                end
            end
            DRAIN: begin
                arr_shift = room;
                if (arr_shift && (sc_q + SCW'(1) == len_q + DEPTH_C))
                    state_d = FINISH;
            end
            FINISH: begin
                if (slot_ok) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (arr_shift)
            sc_d = sc_q + SCW'(1);
    end

    always_comb begin
        ov_d = ov_q;
        od_d = od_q;
        if (capture) begin
            ov_d = 1'b1;
            od_d = arr_out;
        end else if (ov_q && out_ready) begin
            ov_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sc_q    <= '0;
            len_q   <= '0;
            ov_q    <= 1'b0;
            od_q    <= '0;
        end else begin
            state_q <= state_d;
            sc_q    <= sc_d;
            len_q   <= len_d;
            ov_q    <= ov_d;
            od_q    <= od_d;
        end
    end

    assign out_valid = ov_q;
    assign out_data  = od_q;
    assign busy      = (state_q != IDLE);

endmodule
